// File: rtl/ingress_queue.sv
// Show-ahead ingress FIFO with a registered head word, feeding the switch scheduler.
// Optional INGRESS_DROP_NULL_DEST_EN: consume but discard words whose destination field is 2'b00.
module ingress_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         data,
    output logic                     empty,
    output logic                     full,
    input  logic                     rdreq,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             accept, wr_en, rd_en;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign count    = count_q;
    assign data     = data_q;
    assign accept   = in_valid && in_ready;
    assign rd_en    = rdreq && !empty;

`ifdef INGRESS_DROP_NULL_DEST_EN
    logic        is_null;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign is_null  = (in_data[1:0] == 2'b00);
    assign wr_en    = accept && !is_null;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && is_null && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`else
    assign wr_en    = accept;
    assign drop_cnt = '0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // New head is the incoming word when it lands exactly at the next read slot.
        if (count_d != '0) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                data_d = in_data;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_ingress_queue.sv
// Randomized and directed bench for ingress_queue against a queue-based reference model.
module tb_ingress_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] data;
    logic             empty;
    logic             full;
    logic             rdreq = 1'b0;
    logic [4:0]       count;
    logic [15:0]      drop_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    ingress_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data     (data),
        .empty    (empty),
        .full     (full),
        .rdreq    (rdreq),
        .count    (count),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus the last head shown.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_head = '0;
    int               m_drops = 0;

    always @(posedge clk) begin
        bit acc, pop;
        if (reset) begin
            mq.delete();
            m_head  = '0;
            m_drops = 0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            pop = rdreq && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (acc) begin
`ifdef INGRESS_DROP_NULL_DEST_EN
                if (in_data[1:0] == 2'b00) begin
                    if (m_drops < 65535) m_drops++;
                end else begin
                    mq.push_back(in_data);
                end
`else
                mq.push_back(in_data);
`endif
            end
            if (mq.size() > 0) m_head = mq[0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count", 32'(count), 32'(mq.size()));
            check("m_empty", 32'(empty), 32'(mq.size() == 0));
            check("m_full", 32'(full), 32'(mq.size() == DEPTH));
            check("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
            check("m_data", 32'(data), 32'(m_head));
            check("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
        end
    end

    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        rdreq    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, '0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        reset  = 1'b0;
        chk_en = 1'b1;
        check_reset_state("rst");

        // Three back-to-back writes, then three pops.
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h42, 1'b0);
        cycle(1'b1, 8'h83, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("w3_count", 32'(count), 32'd3);
        check("w3_data", 32'(data), 32'h01);
        check("w3_empty", 32'(empty), 32'd0);
        cycle(1'b0, '0, 1'b1);
        check("pop1_data", 32'(data), 32'h42);
        cycle(1'b0, '0, 1'b1);
        check("pop2_data", 32'(data), 32'h83);
        cycle(1'b0, '0, 1'b1);
        check("pop3_empty", 32'(empty), 32'd1);
        check("pop3_count", 32'(count), 32'd0);
        check("pop3_hold", 32'(data), 32'h83);

        // Null-destination handling.
        do_reset();
        cycle(1'b1, 8'h10, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h20, 1'b0);
        cycle(1'b0, '0, 1'b0);
`ifdef INGRESS_DROP_NULL_DEST_EN
        check("drop_count", 32'(count), 32'd1);
        check("drop_data", 32'(data), 32'h11);
        check("drop_cnt", 32'(drop_cnt), 32'd2);
`else
        check("drop_count", 32'(count), 32'd3);
        check("drop_data", 32'(data), 32'h10);
        check("drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        // Fill to full, hold the 17th word, pop once, then accept it.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'((i << 2) | 1), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'd16);
        cycle(1'b1, 8'h41, 1'b0);
        check("held_count", 32'(count), 32'd16);
        cycle(1'b1, 8'h41, 1'b1);
        check("popfull_ready", 32'(in_ready), 32'd1);
        check("popfull_count", 32'(count), 32'd15);
        check("popfull_data", 32'(data), 32'h05);
        cycle(1'b1, 8'h41, 1'b0);
        check("refill_count", 32'(count), 32'd16);

        // Reset mid-traffic with count 9.
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
        check("pre_rst_count", 32'(count), 32'd9);
        reset = 1'b1;
        cycle(1'b1, 8'h55, 1'b1);
        reset = 1'b0;
        check_reset_state("midrst");
        cycle(1'b1, 8'h02, 1'b0);
        check("post_rst_data", 32'(data), 32'h02);
        check("post_rst_count", 32'(count), 32'd1);

        // rdreq held while empty, then a single write.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        check("idle_rd_count", 32'(count), 32'd0);
        cycle(1'b1, 8'h07, 1'b1);
        check("single_data", 32'(data), 32'h07);
        check("single_count", 32'(count), 32'd1);
        cycle(1'b0, '0, 1'b1);
        check("single_popped", 32'(count), 32'd0);

        // Sustained write+pop at occupancy 5 across pointer wrap.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'((i << 2) | 2), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'(($urandom_range(0, 63) << 2) | 3), 1'b1);
            check("stream_count", 32'(count), 32'd5);
        end
        cycle(1'b0, '0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        reset = 1'b0;
        cycle(1'b0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
